// File: rtl/filter_sweep_controller_pkg.sv
// Shared types and constants for the filter frequency-response sweep controller.
//   CONFIG_REG_WIDTH    : width of period / settle / measure configuration words
//   WORD_WIDTH          : width of the signed filter output samples
//   sweep_flush_default : default number of cycles the datapath is held in reset per point
//   sweep_state_t       : sweep sequencer states
package filter_sweep_controller_pkg;

    localparam int CONFIG_REG_WIDTH    = 16;
    localparam int WORD_WIDTH          = 16;
    localparam int sweep_flush_default = 16;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        SETTLE,
        MEASURE,
        REPORT,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/peak_tracker.sv
// Signed running maximum / minimum of a qualified sample stream.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : preload max to most-negative and min to most-positive
//   in        : signed sample
//   in_valid  : sample qualifier
//   max_out   : largest sample seen since the last clear
//   min_out   : smallest sample seen since the last clear
module peak_tracker
    import filter_sweep_controller_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    in_valid,
    output logic signed [WIDTH-1:0] max_out,
    output logic signed [WIDTH-1:0] min_out
);

    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_out <= MOST_NEG;
            min_out <= MOST_POS;
        end else if (clr) begin
            max_out <= MOST_NEG;
            min_out <= MOST_POS;
        end else if (in_valid) begin
            if (in > max_out) max_out <= in;
            if (in < min_out) min_out <= in;
        end
    end

endmodule

// File: rtl/filter_sweep_controller.sv
// Frequency-response sweep sequencer for the sine_gen -> cascade_low_pass_filter
// datapath. For each period point it flushes the datapath, discards a number of
// settling samples, measures peak-to-peak amplitude and streams one result out.
//   clk, rst                 : clock, asynchronous active-high reset
//   start / abort            : begin a sweep when idle / cancel from any state
//   period_start/stop/step   : inclusive period range and increment
//   settle_cycles            : valid samples discarded after the flush
//   measure_cycles           : valid samples measured (0 behaves as 1)
//   stage_mask_in            : filter stage mask, latched at start
//   sample_in, sample_valid  : filter output stream
//   period_out, stage_en_out : datapath programming
//   filt_rst                 : datapath reset, high outside SETTLE/MEASURE/REPORT
//   res_valid/ready/period/pp: result stream (pp is unsigned max-min)
//   busy, done, cfg_err      : status; done and cfg_err are one-cycle pulses
module filter_sweep_controller
    import filter_sweep_controller_pkg::*;
#(
    parameter int NUM_STAGES   = 8,
    parameter int FLUSH_CYCLES = sweep_flush_default
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [CONFIG_REG_WIDTH-1:0]   period_start,
    input  logic [CONFIG_REG_WIDTH-1:0]   period_stop,
    input  logic [CONFIG_REG_WIDTH-1:0]   period_step,
    input  logic [CONFIG_REG_WIDTH-1:0]   settle_cycles,
    input  logic [CONFIG_REG_WIDTH-1:0]   measure_cycles,
    input  logic [NUM_STAGES-1:0]         stage_mask_in,
    input  logic signed [WORD_WIDTH-1:0]  sample_in,
    input  logic                          sample_valid,
    output logic [CONFIG_REG_WIDTH-1:0]   period_out,
    output logic [NUM_STAGES-1:0]         stage_en_out,
    output logic                          filt_rst,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [CONFIG_REG_WIDTH-1:0]   res_period,
    output logic [WORD_WIDTH:0]           res_pp,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);

    localparam int CW  = CONFIG_REG_WIDTH;
    localparam int WW  = WORD_WIDTH;
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

    // Difference of two signed words, widened by one bit so it can never wrap.
    function automatic logic [WW:0] peak_to_peak(input logic signed [WW-1:0] hi,
                                                 input logic signed [WW-1:0] lo);
        return {hi[WW-1], hi} - {lo[WW-1], lo};
    endfunction

    sweep_state_t state_q, state_d;

    logic [CW-1:0]         period_q, period_d;   // also the current sweep point
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  filt_rst_q, filt_rst_d;
    logic                  res_valid_q, res_valid_d;
    logic [CW-1:0]         res_period_q, res_period_d;
    logic [WW:0]           res_pp_q, res_pp_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [FCW-1:0]        flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]         smp_cnt_q, smp_cnt_d;

    logic [CW-1:0] stop_q, step_q, settle_q, meas_q;
    logic          load_cfg;
    logic          cfg_ok;
    logic [CW:0]   next_period;
    logic [CW-1:0] meas_last;

    logic                 peak_clr, peak_en;
    logic signed [WW-1:0] pk_max, pk_min;
    logic signed [WW-1:0] max_incl, min_incl;

    peak_tracker #(.WIDTH(WW)) u_peak (
        .clk      (clk),
        .rst      (rst),
        .clr      (peak_clr),
        .in       (sample_in),
        .in_valid (peak_en),
        .max_out  (pk_max),
        .min_out  (pk_min)
    );

    assign cfg_ok    = (period_start <= period_stop) && (period_step != '0) && (period_start != '0);
    assign meas_last = (meas_q == '0) ? '0 : meas_q - CW'(1);

    // The tracker registers the final sample on the same edge the result is
    // captured, so fold that sample in here to keep the result in step.
    assign max_incl = (sample_in > pk_max) ? sample_in : pk_max;
    assign min_incl = (sample_in < pk_min) ? sample_in : pk_min;

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        stage_d      = stage_q;
        res_valid_d  = res_valid_q;
        res_period_d = res_period_q;
        res_pp_d     = res_pp_q;
        flush_cnt_d  = flush_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;
        load_cfg     = 1'b0;
        peak_clr     = 1'b0;
        peak_en      = 1'b0;
        next_period  = {1'b0, period_q} + {1'b0, step_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        load_cfg    = 1'b1;
                        period_d    = period_start;
                        stage_d     = stage_mask_in;
                        flush_cnt_d = '0;
                        state_d     = FLUSH;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    smp_cnt_d = '0;
                    state_d   = SETTLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FCW'(1);
                end
            end
            SETTLE: begin
                // Clearing throughout SETTLE guarantees a clean tracker on MEASURE entry.
                peak_clr = 1'b1;
                if (settle_q == '0) begin
                    smp_cnt_d = '0;
                    state_d   = MEASURE;
                end else if (sample_valid) begin
                    if (smp_cnt_q == settle_q - CW'(1)) begin
                        smp_cnt_d = '0;
                        state_d   = MEASURE;
                    end else begin
                        smp_cnt_d = smp_cnt_q + CW'(1);
                    end
                end
            end
            MEASURE: begin
                peak_en = sample_valid;
                if (sample_valid) begin
                    if (smp_cnt_q == meas_last) begin
                        res_valid_d  = 1'b1;
                        res_period_d = period_q;
                        res_pp_d     = peak_to_peak(max_incl, min_incl);
                        state_d      = REPORT;
                    end else begin
                        smp_cnt_d = smp_cnt_q + CW'(1);
                    end
                end
            end
            REPORT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    // The extra carry bit catches periods that would wrap past the maximum.
                    if (next_period[CW] || (next_period[CW-1:0] > stop_q)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        period_d    = next_period[CW-1:0];
                        flush_cnt_d = '0;
                        state_d     = FLUSH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d     = IDLE;
            period_d    = period_q;
            stage_d     = stage_q;
            res_valid_d = 1'b0;
            done_d      = 1'b0;
            cfg_err_d   = 1'b0;
            load_cfg    = 1'b0;
        end

        busy_d     = (state_d != IDLE);
        filt_rst_d = (state_d == IDLE) || (state_d == FLUSH) || (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            period_q     <= CW'(1);
            stage_q      <= '0;
            filt_rst_q   <= 1'b1;
            res_valid_q  <= 1'b0;
            res_period_q <= '0;
            res_pp_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            flush_cnt_q  <= '0;
            smp_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            stage_q      <= stage_d;
            filt_rst_q   <= filt_rst_d;
            res_valid_q  <= res_valid_d;
            res_period_q <= res_period_d;
            res_pp_q     <= res_pp_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            flush_cnt_q  <= flush_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
        end
    end

    // Sweep configuration is pure data, captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (load_cfg) begin
            stop_q   <= period_stop;
            step_q   <= period_step;
            settle_q <= settle_cycles;
            meas_q   <= measure_cycles;
        end
    end

    assign period_out   = period_q;
    assign stage_en_out = stage_q;
    assign filt_rst     = filt_rst_q;
    assign res_valid    = res_valid_q;
    assign res_period   = res_period_q;
    assign res_pp       = res_pp_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_filter_sweep_controller.sv
`timescale 1ns/1ps
module tb_filter_sweep_controller;
    import filter_sweep_controller_pkg::*;

    localparam int CW = CONFIG_REG_WIDTH;
    localparam int WW = WORD_WIDTH;
    localparam int NS = 8;
    localparam int FC = 4;

    logic                 clk = 1'b0;
    logic                 rst, start, abort;
    logic [CW-1:0]        period_start, period_stop, period_step, settle_cycles, measure_cycles;
    logic [NS-1:0]        stage_mask_in;
    logic signed [WW-1:0] sample_in;
    logic                 sample_valid;
    logic [CW-1:0]        period_out;
    logic [NS-1:0]        stage_en_out;
    logic                 filt_rst, res_valid, res_ready;
    logic [CW-1:0]        res_period;
    logic [WW:0]          res_pp;
    logic                 busy, done, cfg_err;

    int checks = 0;
    int errors = 0;

    logic                 stall_mode = 1'b0;
    logic                 ph = 1'b0;
    logic                 tog = 1'b0;
    logic signed [WW-1:0] drv_hi = '0;
    logic signed [WW-1:0] drv_lo = '0;

    filter_sweep_controller #(.NUM_STAGES(NS), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .period_start   (period_start),
        .period_stop    (period_stop),
        .period_step    (period_step),
        .settle_cycles  (settle_cycles),
        .measure_cycles (measure_cycles),
        .stage_mask_in  (stage_mask_in),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .period_out     (period_out),
        .stage_en_out   (stage_en_out),
        .filt_rst       (filt_rst),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_period     (res_period),
        .res_pp         (res_pp),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err)
    );

    always #2 clk = ~clk;

    // Sample source: alternates between drv_hi and drv_lo every cycle. In stall
    // mode the qualifier is low on the first post-flush edge, then toggles.
    always @(negedge clk) begin
        if (stall_mode) begin
            if (filt_rst) begin
                sample_valid = 1'b0;
                ph = 1'b0;
            end else begin
                sample_valid = ph;
                ph = ~ph;
            end
        end else begin
            sample_valid = 1'b1;
        end
        tog = ~tog;
        sample_in = tog ? drv_hi : drv_lo;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [CW-1:0]        pstart;
        logic [CW-1:0]        pstop;
        logic [CW-1:0]        pstep;
        logic [CW-1:0]        settle;
        logic [CW-1:0]        meas;
        logic [NS-1:0]        mask;
        logic signed [WW-1:0] hi;
        logic signed [WW-1:0] lo;
        int                   nres;
        logic [WW:0]          pp;
        logic                 err;
    } vec_t;

    vec_t vecs[8];

    task automatic set_cfg(input logic [CW-1:0] ps, input logic [CW-1:0] pe, input logic [CW-1:0] st,
                           input logic [CW-1:0] se, input logic [CW-1:0] me, input logic [NS-1:0] mk);
        period_start   = ps;
        period_stop    = pe;
        period_step    = st;
        settle_cycles  = se;
        measure_cycles = me;
        stage_mask_in  = mk;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(name, busy, 0);
    endtask

    task automatic run_sweep(input int idx, input vec_t v);
        int            nres, ndone, cyc;
        logic [CW-1:0] expp, lastp, p_before;
        string         tag;
        tag = $sformatf("v%0d", idx);
        p_before = period_out;
        drv_hi = v.hi;
        drv_lo = v.lo;
        set_cfg(v.pstart, v.pstop, v.pstep, v.settle, v.meas, v.mask);
        pulse_start();
        chk({tag, "_cfg_err"}, cfg_err, v.err);
        if (v.err) begin
            chk({tag, "_busy_rej"}, busy, 0);
            chk({tag, "_filt_rst_rej"}, filt_rst, 1);
            chk({tag, "_period_rej"}, period_out, p_before);
            @(negedge clk);
            chk({tag, "_cfg_err_pulse"}, cfg_err, 0);
        end else begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_stage_en"}, stage_en_out, v.mask);
            nres = 0; ndone = 0; cyc = 0;
            expp = v.pstart; lastp = v.pstart;
            while (busy && cyc < 5000) begin
                if (res_valid && res_ready) begin
                    chk({tag, "_res_period"}, res_period, expp);
                    chk({tag, "_res_pp"}, res_pp, v.pp);
                    lastp = expp;
                    expp = expp + v.pstep;
                    nres++;
                end
                if (done) ndone++;
                @(negedge clk);
                cyc++;
            end
            chk({tag, "_timeout"}, cyc < 5000, 1);
            chk({tag, "_nres"}, nres, v.nres);
            chk({tag, "_ndone"}, ndone, 1);
            chk({tag, "_period_final"}, period_out, lastp);
            chk({tag, "_stage_final"}, stage_en_out, v.mask);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int cnt, frs, k;
        logic [CW-1:0] rp;
        logic [WW:0]   rpp;

        vecs[0] = '{16'd2,     16'd4,     16'd1, 16'd8, 16'd32, 8'hA5, 16'sd100,   -16'sd100,   3, 17'd200,   1'b0};
        vecs[1] = '{16'd5,     16'd3,     16'd1, 16'd8, 16'd32, 8'h0F, 16'sd100,   -16'sd100,   0, 17'd0,     1'b1};
        vecs[2] = '{16'd2,     16'd4,     16'd0, 16'd8, 16'd32, 8'h0F, 16'sd100,   -16'sd100,   0, 17'd0,     1'b1};
        vecs[3] = '{16'd0,     16'd4,     16'd1, 16'd8, 16'd32, 8'h0F, 16'sd100,   -16'sd100,   0, 17'd0,     1'b1};
        vecs[4] = '{16'hFFFE,  16'hFFFF,  16'd2, 16'd2, 16'd4,  8'hFF, 16'sd32767, -16'sd32768, 1, 17'd65535, 1'b0};
        vecs[5] = '{16'd10,    16'd20,    16'd5, 16'd0, 16'd0,  8'h01, 16'sd7,     -16'sd3,     3, 17'd0,     1'b0};
        vecs[6] = '{16'd3,     16'd3,     16'd1, 16'd1, 16'd2,  8'h3C, -16'sd50,   -16'sd80,    1, 17'd30,    1'b0};
        vecs[7] = '{16'd100,   16'd107,   16'd3, 16'd3, 16'd5,  8'h80, 16'sd1000,  16'sd999,    3, 17'd1,     1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        set_cfg('0, '0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);

        chk("rst_period_out", period_out, 1);
        chk("rst_stage_en", stage_en_out, 0);
        chk("rst_filt_rst", filt_rst, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_period", res_period, 0);
        chk("rst_res_pp", res_pp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_sweep(i, vecs[i]);
            repeat (2) @(negedge clk);
        end

        // Latency from start to first result and flush length.
        drv_hi = 16'sd20; drv_lo = -16'sd20;
        set_cfg(16'd9, 16'd9, 16'd1, 16'd8, 16'd32, 8'h11);
        @(negedge clk);
        start = 1'b1;
        cnt = 0; frs = -1;
        do begin
            @(negedge clk);
            start = 1'b0;
            cnt++;
            if (!filt_rst && frs < 0) frs = cnt;
        end while (!res_valid && cnt < 500);
        chk("lat_flush_len", frs, FC + 1);
        chk("lat_first_result", cnt, FC + 8 + 32 + 1);
        wait_idle("lat_idle");

        // Backpressure: result held while res_ready is low.
        res_ready = 1'b0;
        drv_hi = 16'sd40; drv_lo = -16'sd10;
        set_cfg(16'd2, 16'd3, 16'd1, 16'd2, 16'd4, 8'h55);
        pulse_start();
        k = 0;
        while (!res_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("bp_reach_report", res_valid, 1);
        rp = res_period; rpp = res_pp;
        chk("bp_period_first", rp, 2);
        chk("bp_pp_first", rpp, 50);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp_res_valid_hold", res_valid, 1);
            chk("bp_res_period_hold", res_period, rp);
            chk("bp_res_pp_hold", res_pp, rpp);
            chk("bp_filt_rst_low", filt_rst, 0);
            chk("bp_period_out_hold", period_out, 2);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", res_valid, 0);
        chk("bp_flush_after", filt_rst, 1);
        chk("bp_next_period", period_out, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("bp_abort_idle", busy, 0);

        // Stalled samples: qualifier high every other cycle.
        stall_mode = 1'b1;
        set_cfg(16'd5, 16'd5, 16'd1, 16'd4, 16'd4, 8'h01);
        pulse_start();
        k = 0;
        while (filt_rst && k < 100) begin
            @(negedge clk);
            k++;
        end
        cnt = 0;
        while (!res_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("stall_report_delay", cnt, 2 * (4 + 4));
        wait_idle("stall_idle");
        stall_mode = 1'b0;

        // Abort during MEASURE.
        drv_hi = 16'sd5; drv_lo = -16'sd5;
        set_cfg(16'd4, 16'd6, 16'd1, 16'd2, 16'd32, 8'h22);
        pulse_start();
        repeat (FC + 6) @(negedge clk);
        chk("ab_in_measure", busy && !filt_rst && !res_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_filt_rst", filt_rst, 1);
        chk("ab_res_valid", res_valid, 0);
        chk("ab_done", done, 0);
        k = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (res_valid || done || busy) k++;
        end
        chk("ab_quiet_after", k, 0);

        // Asynchronous reset in FLUSH, then a fresh sweep.
        set_cfg(16'd7, 16'd8, 16'd1, 16'd2, 16'd4, 8'hC3);
        pulse_start();
        @(negedge clk);
        chk("ar_in_flush", period_out, 7);
        #1 rst = 1'b1;
        #0.5;
        chk("ar_period_out", period_out, 1);
        chk("ar_stage_en", stage_en_out, 0);
        chk("ar_filt_rst", filt_rst, 1);
        chk("ar_busy", busy, 0);
        chk("ar_res_valid", res_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_sweep(100, vecs[6]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_sweep_controller.md
Name: filter_sweep_controller

Overview:
Sequences a frequency-response sweep of the sine_gen → cascade_low_pass_filter datapath in hardware. It steps the sine_gen period over a configured range and programs the filter stage-enable mask. For each point it flushes the filter, waits a settle time, then measures the peak-to-peak amplitude of the filter output. It streams one result per period point over a valid/ready interface, so the CPU or a FIFO can build a Bode magnitude plot without a simulator.

Parameters:
NUM_STAGES, 8, width of the filter stage-enable mask driven to cascade_low_pass_filter
FLUSH_CYCLES, 16, cycles filt_rst is held high before each sweep point (≥1)

Ports:
clk  in  1  250 MHz system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse; begins a sweep when idle
abort  in  1  single-cycle pulse; cancels a sweep from any state
period_start  in  config_reg_width  first period value
period_stop  in  config_reg_width  last period value, inclusive
period_step  in  config_reg_width  period increment
settle_cycles  in  config_reg_width  valid samples discarded after flush
measure_cycles  in  config_reg_width  valid samples used for the measurement
stage_mask_in  in  NUM_STAGES  stage mask, latched at start
sample_in  in  word_width  filter output, signed two's complement
sample_valid  in  1  sample_in qualifier
period_out  out  config_reg_width  drives sine_gen period
stage_en_out  out  NUM_STAGES  drives filter stage enables
filt_rst  out  1  datapath reset for sine_gen and filter, active-high
res_valid  out  1  result available
res_ready  in  1  result consumed
res_period  out  config_reg_width  period of this result
res_pp  out  word_width+1  unsigned max−min over the measure window
busy  out  1  high in every state except IDLE
done  out  1  single-cycle pulse at sweep completion
cfg_err  out  1  single-cycle pulse when start is rejected

Behaviour:
- Reset values: period_out=1, stage_en_out=0, filt_rst=1, res_valid=0, res_period=0, res_pp=0, busy=0, done=0, cfg_err=0. State is IDLE.
- All outputs are registered.
- IDLE:
  - On start, check the configuration. It is valid when period_start≤period_stop, period_step≠0 and period_start≠0.
  - If valid: latch all config inputs and stage_mask_in, set cur_period=period_start, go to FLUSH.
  - If invalid: pulse cfg_err for 1 cycle and stay in IDLE.
  - filt_rst stays 1 while IDLE.
- FLUSH:
  - period_out=cur_period and filt_rst=1 for exactly FLUSH_CYCLES cycles, then go to SETTLE.
  - filt_rst deasserts in the first SETTLE cycle.
- SETTLE:
  - Count settle_cycles valid samples (sample_valid=1); invalid cycles do not count.
  - If settle_cycles=0, SETTLE lasts 1 cycle and goes straight to MEASURE.
- MEASURE:
  - Clear the peak tracker on entry.
  - Track signed max and min of valid samples for max(measure_cycles,1) valid samples.
  - On the last counted sample, go to REPORT.
- REPORT:
  - res_valid=1, res_period=cur_period, res_pp=max−min, computed in word_width+1 bits (never wraps).
  - Outputs stay stable while res_ready=0.
  - On the res_valid&res_ready cycle, form next=cur_period+period_step with config_reg_width+1 bits.
    - If next>period_stop or the add carries out: go to DONE.
    - Otherwise: cur_period=next, go to FLUSH.
  - res_valid drops the cycle after the handshake.
- DONE: pulse done for 1 cycle, go to IDLE. period_out and stage_en_out keep their last values.
- abort: wins over every other event, including a same-cycle start or handshake. Next state is IDLE, res_valid=0, filt_rst=1, no done pulse.
- start while busy is ignored.
- Asynchronous rst mid-sweep returns every output to its reset value immediately.
- Latency: first res_valid appears FLUSH_CYCLES + settle_cycles + measure_cycles + 1 cycles after start, assuming sample_valid is always high.

Decomposition:
- opo_package gains:
  - sweep_state_t enum {IDLE, FLUSH, SETTLE, MEASURE, REPORT, DONE}
  - sweep_flush_default constant = 16
- Sub-module peak_tracker (clk, rst, clr, in, in_valid, max_out, min_out): signed running max/min. clr preloads max=most-negative and min=most-positive.

Test Plan:
- Basic sweep: start=2, stop=4, step=1, settle=8, measure=32, samples alternate +100/−100, res_ready=1 → exactly three results with res_period 2, 3, 4 and res_pp=200 each, then one done pulse and busy=0.
- Invalid config: start with period_start=5, period_stop=3 (then again with step=0) → cfg_err pulses once each time; busy, filt_rst and period_out unchanged.
- Backpressure: hold res_ready=0 for 20 cycles in REPORT → res_valid, res_period and res_pp stable; filt_rst stays 0; no FLUSH until res_ready rises.
- Wrap guard and extremes: period_start=max−1, step=2, stop=max, samples at most-positive and most-negative → one result with res_pp=2^word_width−1, then done with no wrapped period.
- Stalled samples: sample_valid toggles every other cycle, settle=4, measure=4 → REPORT is entered exactly 2×(4+4) cycles after FLUSH ends.
- Abort and reset: abort in MEASURE → IDLE the next cycle, no result, no done. rst asserted mid-FLUSH → all outputs return to reset values asynchronously, and a new start succeeds afterward.
